// File: rtl/sipo_loader.sv
// Serial-in parallel-out word assembler feeding a downstream controlled buffer register.
// Latency: load pulses one cycle after the edge that accepts the final bit of a frame.
// Backpressure: busy is high only in the LOAD cycle; a bit offered then is dropped and must be held.
//
// Ports:
//   clk        single clock, rising edge
//   clr        synchronous active-high reset, highest priority
//   sin        serial data bit, LSB of the word first
//   sin_valid  qualifies sin; accepted when busy=0
//   x          last completed word (buff_len bits), held between frames
//   load       one-cycle pulse marking x as new
//   busy       high when a bit would not be accepted
//   par_err    one-cycle pulse on a bad parity bit (tied 0 without parity)
//
// Optional feature: define SIPO_PARITY_EN to append an even-parity bit to each
// frame; the PAR state then waits for it before the word is released.
module sipo_loader #(
    parameter int buff_len = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                sin,
    input  logic                sin_valid,
    output logic [buff_len-1:0] x,
    output logic                load,
    output logic                busy,
    output logic                par_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
`ifdef SIPO_PARITY_EN
        ,
        PAR   = 2'd3
`endif
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          cnt;
    logic [buff_len-1:0] sreg;
    logic [buff_len-1:0] sreg_nxt;
    logic                accept;
    logic                last_bit;

`ifdef SIPO_PARITY_EN
    // Set when the parity bit was wrong; the LOAD cycle then reports an error
    // instead of a load and x is left untouched.
    logic                err_q;
    logic                par_ok;

    assign par_ok = (sin == ^sreg);
`endif

    assign accept   = sin_valid && !busy;
    assign last_bit = (cnt == 8'(buff_len - 1));

    // Shift register with the incoming bit written at the counter position;
    // used both for the register update and for the word handed to x.
    always_comb begin
        sreg_nxt = sreg;
        for (int i = 0; i < buff_len; i++) begin
            if (cnt == 8'(i)) begin
                sreg_nxt[i] = sin;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, SHIFT: begin
                if (accept) begin
                    if (last_bit) begin
`ifdef SIPO_PARITY_EN
                        state_nxt = PAR;
`else
                        state_nxt = LOAD;
`endif
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
`ifdef SIPO_PARITY_EN
            PAR: begin
                if (accept) begin
                    state_nxt = LOAD;
                end
            end
`endif
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: all handshake outputs decode from the state register
    always_comb begin
        busy    = (state == LOAD);
`ifdef SIPO_PARITY_EN
        load    = (state == LOAD) && !err_q;
        par_err = (state == LOAD) && err_q;
`else
        load    = (state == LOAD);
        par_err = 1'b0;
`endif
    end

    // Datapath: counter, shift register and the output word
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt  <= 8'd0;
            sreg <= '0;
            x    <= '0;
`ifdef SIPO_PARITY_EN
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, SHIFT: begin
                    if (accept) begin
                        sreg <= sreg_nxt;
                        cnt  <= cnt + 8'd1;
`ifndef SIPO_PARITY_EN
                        // x only moves when the word is complete
                        if (last_bit) begin
                            x <= sreg_nxt;
                        end
`endif
                    end
                end
`ifdef SIPO_PARITY_EN
                PAR: begin
                    if (accept) begin
                        if (par_ok) begin
                            x     <= sreg;
                            err_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
`endif
                LOAD: begin
                    cnt <= 8'd0;
`ifdef SIPO_PARITY_EN
                    err_q <= 1'b0;
`endif
                end
                default: begin
                    cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_loader.sv
module tb_sipo_loader;

    logic       clk;
    logic       clr;
    logic       sin;
    logic       sin_valid;
    logic [3:0] x;
    logic       load;
    logic       busy;
    logic       par_err;

    typedef struct {
        logic [3:0] w;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] last_x   = 4'd0;

    sipo_loader #(.buff_len(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .sin       (sin),
        .sin_valid (sin_valid),
        .x         (x),
        .load      (load),
        .busy      (busy),
        .par_err   (par_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running req=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    // Monitor: every load or par_err pulse consumes one expected frame outcome.
    always @(negedge clk) begin
        if (load || par_err) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mon_unexpected act=load%0b/perr%0b req=no_pulse", load, par_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_x", 32'(x), 32'(e.w));
                check("mon_perr", 32'(par_err), 32'(e.err));
                check("mon_busy", 32'(busy), 32'd1);
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        sin       = b;
        sin_valid = 1'b1;
    endtask

    task automatic idle_check(input int n, input logic [3:0] xreq, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sin_valid = 1'b0;
            check(name, 32'(x), 32'(xreq));
        end
    endtask

    // Sends a full frame (LSB first, plus parity when enabled), queues the
    // expected outcome and checks the LOAD-cycle handshake. hold drives
    // sin_valid=1 during the LOAD cycle so that bit must be dropped.
    task automatic send_word(input logic [3:0] w, input logic bad, input logic hold);
        exp_t e;
        e.err = bad;
        e.w   = bad ? last_x : w;
        exp_q.push_back(e);
        if (!bad) last_x = w;
        for (int i = 0; i < 4; i++) begin
            send_bit(w[i]);
        end
`ifdef SIPO_PARITY_EN
        send_bit((^w) ^ bad);
`endif
        @(negedge clk);
        check("lat_load", 32'(load), 32'(!bad));
        check("lat_perr", 32'(par_err), 32'(bad));
        check("lat_busy", 32'(busy), 32'd1);
        sin       = 1'b1;
        sin_valid = hold;
    endtask

    initial begin
        clr       = 1'b1;
        sin       = 1'b0;
        sin_valid = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_x", 32'(x), 32'd0);
            check("rst_load", 32'(load), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_perr", 32'(par_err), 32'd0);
        end
        clr = 1'b0;
        idle_check(1, 4'd0, "idle_x");

        // Bits 1,0,1,1 -> 4'b1101, held afterwards
        send_word(4'b1101, 1'b0, 1'b0);
        idle_check(3, 4'b1101, "hold_x");
        check("idle_busy", 32'(busy), 32'd0);

        // Bits 0,1, gap of 3, then 1,0 -> 4'b0110; x unchanged during the gap
        exp_q.push_back('{w: 4'b0110, err: 1'b0});
        send_bit(1'b0);
        send_bit(1'b1);
        idle_check(3, 4'b1101, "gap_x");
        check("gap_busy", 32'(busy), 32'd0);
        send_bit(1'b1);
        send_bit(1'b0);
`ifdef SIPO_PARITY_EN
        send_bit(1'b0);
`endif
        last_x = 4'b0110;
        @(negedge clk);
        check("gap_load", 32'(load), 32'd1);
        sin_valid = 1'b0;
        idle_check(2, 4'b0110, "gap_hold_x");

        // Back-to-back 4'b1010 then 4'b0101, sin_valid held in LOAD
        send_word(4'b1010, 1'b0, 1'b1);
        send_word(4'b0101, 1'b0, 1'b0);
        idle_check(2, 4'b0101, "b2b_hold_x");

        // Clear after two bits: no load, x=0
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        clr       = 1'b1;
        sin_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("clr_x", 32'(x), 32'd0);
            check("clr_load", 32'(load), 32'd0);
            check("clr_busy", 32'(busy), 32'd0);
        end
        clr    = 1'b0;
        last_x = 4'd0;
        send_word(4'b1111, 1'b0, 1'b0);
        idle_check(1, 4'b1111, "post_clr_x");

        // Clear coinciding with the final bit: pending LOAD discarded
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        sin       = 1'b1;
        sin_valid = 1'b1;
        clr       = 1'b1;
        @(negedge clk);
        check("clr_pend_load", 32'(load), 32'd0);
        check("clr_pend_x", 32'(x), 32'd0);
        clr       = 1'b0;
        sin_valid = 1'b0;
        last_x    = 4'd0;
        idle_check(2, 4'd0, "clr_pend_hold_x");
        send_word(4'b1001, 1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
        // Data 1,1,0,0 with good parity, then a frame with bad parity
        send_word(4'b0011, 1'b0, 1'b0);
        idle_check(1, 4'b0011, "par_ok_x");
        send_word(4'b0001, 1'b1, 1'b0);
        idle_check(2, 4'b0011, "par_bad_x");
`endif

        // Let the monitor drain the scoreboard
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            sin_valid = 1'b0;
        end
        check("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_loader.md
SIPO_LOADER -- requirements
Module: sipo_loader

Interface
REQ-001 Parameter buff_len, default 4, SHALL set the assembled word width; legal range 2..255.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 clr  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 sin  input  1  SHALL carry the serial data bit, sampled only when sin_valid=1.
REQ-005 sin_valid  input  1  SHALL qualify sin; one bit accepted per cycle in which sin_valid=1 and busy=0.
REQ-006 x  output  buff_len  SHALL present the last completed word; it drives the x input of the downstream controlled buffer register.
REQ-007 load  output  1  SHALL be a one-cycle pulse marking x as new; it drives the downstream load input.
REQ-008 busy  output  1  SHALL be high whenever a bit would not be accepted.
REQ-009 par_err  output  1  SHALL be a one-cycle parity-error pulse; the port is always present.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT, PAR and LOAD; PAR exists only when SIPO_PARITY_EN is defined.
REQ-011 An internal shift register and an 8-bit bit counter SHALL assemble the word; x SHALL NOT change while bits accumulate.
REQ-012 Bits SHALL be LSB first: the k-th accepted bit (k=0..buff_len-1) lands in word bit k.
REQ-013 IDLE: an accepted bit SHALL store bit 0, set the counter to 1 and go to SHIFT; with buff_len bits already collected, the FSM goes to LOAD or PAR instead.
REQ-014 SHIFT: each accepted bit SHALL store at the counter position and increment the counter; sin_valid=0 SHALL hold all state (gaps allowed).
REQ-015 On acceptance of bit buff_len-1, the FSM SHALL go to LOAD, or to PAR when SIPO_PARITY_EN is defined.
REQ-016 LOAD: for exactly one cycle, x SHALL equal the assembled word, load=1 and busy=1; the next state SHALL be IDLE with the counter cleared.
REQ-017 Latency: load SHALL assert in the cycle immediately after the edge that accepted the last bit (parity bit when enabled).
REQ-018 busy SHALL be 1 in LOAD and 0 in IDLE, SHIFT and PAR.
REQ-019 sin_valid asserted in LOAD SHALL be ignored; the bit SHALL be lost, and the sender SHALL hold it until busy=0.
REQ-020 load SHALL be 0 in every state other than LOAD.
REQ-021 Back-to-back frames SHALL be supported: a bit accepted in the first cycle after LOAD starts a new frame.

Reset
REQ-022 With clr=1 at a rising edge, the block SHALL enter IDLE, clear the counter and shift register, and drive x=0, load=0, busy=0 and par_err=0.
REQ-023 clr SHALL take priority over all activity; a partial frame or a pending LOAD SHALL be discarded and no load pulse emitted.
REQ-024 Outputs SHALL stay at reset values for as long as clr=1.

Configuration
REQ-025 Macro SIPO_PARITY_EN, when defined, SHALL add state PAR, which waits for one more accepted bit: the even-parity bit, equal to the XOR of the data bits.
REQ-026 With SIPO_PARITY_EN, a correct parity bit SHALL lead to LOAD.
REQ-027 With SIPO_PARITY_EN, a wrong parity bit SHALL give for one cycle par_err=1, load=0, busy=1 and x unchanged, then IDLE.
REQ-028 Without SIPO_PARITY_EN, par_err SHALL be tied 0 and frames SHALL be buff_len bits.

Verification (buff_len=4)
REQ-029 After reset, bits 1,0,1,1 on consecutive cycles -> load=1 for one cycle the cycle after bit 3, x=4'b1101; x holds afterwards.
REQ-030 Bits 0,1 with 3 idle cycles, then 1,0 -> single load pulse, x=4'b0110; x unchanged during the gap.
REQ-031 Two frames 4'b1010 and 4'b0101 back-to-back, with sin_valid held during LOAD -> LOAD-cycle bit dropped, busy=1 in LOAD, two load pulses, x shows each word in order.
REQ-032 clr=1 after two bits of a frame -> x=0 and no load; the next full frame 4'b1111 loads correctly.
REQ-033 SIPO_PARITY_EN: data 1,1,0,0 with parity 0 -> load, x=4'b0011; with parity 1 -> par_err pulse, load=0, x keeps its previous value.
